// File: rtl/timer_pkg.sv
// Shared encodings for the 8-bit timer clock controller: FSM states and clock-select codes.
package timer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StRun    = ST_RUN,
    StSwitch = ST_SWITCH
  } state_e;

  localparam logic [1:0] CKS_DIV2  = 2'd0;
  localparam logic [1:0] CKS_DIV4  = 2'd1;
  localparam logic [1:0] CKS_DIV8  = 2'd2;
  localparam logic [1:0] CKS_DIV16 = 2'd3;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler counter; flags the cycle in which the selected divide boundary is reached.
module timer_prescaler #(
  parameter int unsigned PRE_W = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic [SEL_W-1:0] sel,
  output logic             due
);

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] mask;

  always_ff @(posedge pclk) begin
    if (preset || clr) begin
      pre_cnt <= '0;
    end else if (cnt_en) begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Low sel+1 bits all ones marks the last cycle of a 2^(sel+1) period.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PRE_W; i++) begin
      mask[i] = (i <= 32'(sel));
    end
  end

  assign due = cnt_en && ((pre_cnt & mask) == mask);

endmodule

// File: rtl/timer_clk_ctrl.sv
// Timer prescaler/clock-select controller: start/stop sequencing and boundary-aligned select changes.
module timer_clk_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned PRE_W = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en_i,
  input  logic [SEL_W-1:0] cks_i,
  input  logic             cks_wr_i,
  output logic             tick_o,
  output logic [SEL_W-1:0] cks_o,
  output logic             cks_ack_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic [SEL_W-1:0] cks_q, cks_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             clr, cnt_en, due;

  timer_prescaler #(
    .PRE_W(PRE_W),
    .SEL_W(SEL_W)
  ) u_pre (
    .pclk  (pclk),
    .preset(preset),
    .clr   (clr),
    .cnt_en(cnt_en),
    .sel   (cks_q),
    .due   (due)
  );

  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    cks_d      = cks_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    clr        = 1'b0;
    cnt_en     = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        clr = 1'b1;
        if (cks_wr_i) begin
          cks_d = cks_i;
          ack_d = 1'b1;
        end
        if (en_i) state_d = StRun;
      end
      StRun: begin
        if (!en_i) begin
          // Stop wins over a simultaneous request, which is then applied directly.
          clr     = 1'b1;
          state_d = StIdle;
          if (cks_wr_i) begin
            cks_d = cks_i;
            ack_d = 1'b1;
          end
        end else begin
          tick_d = due;
          if (cks_wr_i) begin
            pend_sel_d = cks_i;
            state_d    = StSwitch;
          end
        end
      end
      StSwitch: begin
        if (!en_i) begin
          clr     = 1'b1;
          state_d = StIdle;
          cks_d   = cks_wr_i ? cks_i : pend_sel_q;
          ack_d   = 1'b1;
        end else begin
          tick_d = due;
          if (cks_wr_i) begin
            // A late request restarts the wait; the boundary tick still goes out at the old rate.
            pend_sel_d = cks_i;
          end else if (due) begin
            cks_d   = pend_sel_q;
            clr     = 1'b1;
            ack_d   = 1'b1;
            state_d = StRun;
          end
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= StIdle;
      pend_sel_q <= SEL_W'(CKS_DIV2);
      cks_q      <= SEL_W'(CKS_DIV2);
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_sel_q <= pend_sel_d;
      cks_q      <= cks_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

  assign tick_o    = tick_q;
  assign cks_o     = cks_q;
  assign cks_ack_o = ack_q;
  assign busy_o    = (state_q == StSwitch);

endmodule

// File: tb/tb_timer_clk_ctrl.sv
// Bench for timer_clk_ctrl: cycle scoreboard against a behavioural model plus directed scenario checks.
module tb_timer_clk_ctrl;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       en_i = 1'b0;
  logic [1:0] cks_i = 2'd0;
  logic       cks_wr_i = 1'b0;
  logic       tick_o;
  logic [1:0] cks_o;
  logic       cks_ack_o;
  logic       busy_o;

  timer_clk_ctrl #(
    .PRE_W(4),
    .SEL_W(2)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .en_i     (en_i),
    .cks_i    (cks_i),
    .cks_wr_i (cks_wr_i),
    .tick_o   (tick_o),
    .cks_o    (cks_o),
    .cks_ack_o(cks_ack_o),
    .busy_o   (busy_o)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int tick;
    int ack;
    int busy;
    int cks;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Behavioural model state: 0 idle, 1 run, 2 switch.
  int m_st = 0, m_cnt = 0, m_pend = 0, m_cks = 0, m_tick = 0, m_ack = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model(input int rst, input int en, input int wr, input int sel);
    int per, due;
    if (rst != 0) begin
      m_st = 0; m_cnt = 0; m_pend = 0; m_cks = 0; m_tick = 0; m_ack = 0;
      return;
    end
    m_tick = 0;
    m_ack  = 0;
    per = 2 << m_cks;
    due = ((m_cnt % per) == per - 1) ? 1 : 0;
    case (m_st)
      0: begin
        m_cnt = 0;
        if (wr != 0) begin m_cks = sel; m_ack = 1; end
        if (en != 0) m_st = 1;
      end
      1: begin
        if (en == 0) begin
          m_st = 0; m_cnt = 0;
          if (wr != 0) begin m_cks = sel; m_ack = 1; end
        end else begin
          m_tick = due;
          m_cnt  = (m_cnt + 1) % 16;
          if (wr != 0) begin m_pend = sel; m_st = 2; end
        end
      end
      default: begin
        if (en == 0) begin
          m_st = 0; m_cnt = 0; m_ack = 1;
          m_cks = (wr != 0) ? sel : m_pend;
        end else begin
          m_tick = due;
          if (wr != 0) begin
            m_pend = sel;
            m_cnt  = (m_cnt + 1) % 16;
          end else if (due != 0) begin
            m_cks = m_pend; m_cnt = 0; m_ack = 1; m_st = 1;
          end else begin
            m_cnt = (m_cnt + 1) % 16;
          end
        end
      end
    endcase
  endtask

  // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
  task automatic step(input int rst, input int en, input int wr, input int sel);
    exp_t e;
    preset   = (rst != 0);
    en_i     = (en != 0);
    cks_wr_i = (wr != 0);
    cks_i    = 2'(sel);
    model(rst, en, wr, sel);
    e.tick = m_tick;
    e.ack  = m_ack;
    e.busy = (m_st == 2) ? 1 : 0;
    e.cks  = m_cks;
    sb.push_back(e);
    @(posedge pclk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("sb_tick", int'(tick_o), e.tick);
    chk("sb_ack", int'(cks_ack_o), e.ack);
    chk("sb_busy", int'(busy_o), e.busy);
    chk("sb_cks", int'(cks_o), e.cks);
  endtask

  initial begin
    int ticks, last, s0, acks, n, first_ack, found;
    int tq[$];

    #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // T1: reset for two cycles while running
    step(0, 0, 1, 2);
    step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t1_tick", int'(tick_o), 0);
    chk("t1_cks", int'(cks_o), 0);
    chk("t1_busy", int'(busy_o), 0);
    chk("t1_ack", int'(cks_ack_o), 0);
    step(0, 0, 0, 0);

    // T2: each divide rate over 64 cycles
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, k);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      ticks = 0;
      last  = 0;
      for (int j = 1; j <= 64; j++) begin
        step(0, 1, 0, 0);
        if (tick_o === 1'b1) begin
          chk("t2_gap", j - last, 2 << k);
          last = j;
          ticks++;
        end
      end
      chk("t2_count", ticks, 64 >> (k + 1));
      step(0, 0, 0, 0);
    end

    // T3: switch /16 -> /2 requested 5 cycles after a tick
    step(0, 0, 1, 3);
    step(0, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(0, 1, 0, 0);
      if (tick_o === 1'b1) found = 1;
    end
    chk("t3_found_tick", found, 1);
    s0 = cyc;
    for (int m = 1; m <= 4; m++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("t3_busy", int'(busy_o), 1);
    first_ack = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0);
      if (tick_o === 1'b1) tq.push_back(cyc - s0);
      if (cks_ack_o === 1'b1 && first_ack < 0) first_ack = cyc - s0;
    end
    chk("t3_tick0", (tq.size() > 0) ? tq[0] : -1, 16);
    chk("t3_tick1", (tq.size() > 1) ? tq[1] : -1, 18);
    chk("t3_tick2", (tq.size() > 2) ? tq[2] : -1, 20);
    chk("t3_ack", first_ack, 16);

    // T4: last request wins inside SWITCH
    step(0, 1, 1, 3);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step(0, 1, 0, 0);
      if (cks_ack_o === 1'b1) found = 1;
    end
    chk("t4_first_ack", found, 1);
    acks = 0;
    step(0, 1, 1, 1);
    acks += int'(cks_ack_o);
    step(0, 1, 0, 0);
    acks += int'(cks_ack_o);
    step(0, 1, 1, 3);
    acks += int'(cks_ack_o);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 0);
      acks += int'(cks_ack_o);
    end
    chk("t4_acks", acks, 1);
    chk("t4_cks", int'(cks_o), 3);

    // T5: stop while a switch is pending
    step(0, 1, 1, 2);
    chk("t5_busy", int'(busy_o), 1);
    step(0, 0, 0, 0);
    chk("t5_tick", int'(tick_o), 0);
    chk("t5_ack", int'(cks_ack_o), 1);
    chk("t5_cks", int'(cks_o), 2);
    chk("t5_busy_off", int'(busy_o), 0);
    chk("t5_idle", int'(dut.state_q), 0);
    step(0, 1, 0, 0);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      step(0, 1, 0, 0);
      if (tick_o === 1'b1) n = i;
    end
    chk("t5_first_tick", n, 8);

    // T6: write in IDLE, then write together with stop
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("t6_idle_ack", int'(cks_ack_o), 1);
    chk("t6_idle_cks", int'(cks_o), 1);
    chk("t6_idle_busy", int'(busy_o), 0);
    step(0, 0, 0, 0);
    chk("t6_ack_once", int'(cks_ack_o), 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 3);
    chk("t6_stop_ack", int'(cks_ack_o), 1);
    chk("t6_stop_cks", int'(cks_o), 3);
    chk("t6_stop_busy", int'(busy_o), 0);
    chk("t6_stop_idle", int'(dut.state_q), 0);

    // Random traffic cross-checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 97 == 0) ? 1 : 0, ($urandom % 9 != 0) ? 1 : 0,
           ($urandom % 7 == 0) ? 1 : 0, int'($urandom % 4));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
